// File: rtl/sram_responder.sv
// Synchronous SRAM-style slave: 16-bit word array behind CE/OE/WE/UB/LB strobes, reads valid READ_LATENCY edges after the request.
// Optional SRAM_RESPONDER_STATS_EN adds saturating read_count/write_count outputs.
module sram_responder #(
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        OE,
  input  logic        WE,
  input  logic        UB,
  input  logic        LB,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
`ifdef SRAM_RESPONDER_STATS_EN
  output logic [15:0] read_count,
  output logic [15:0] write_count,
`endif
  output logic        Ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE_HOLD} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [19:0] raddr, raddr_nxt;
  logic [15:0] rdata;
  logic [15:0] mem [DEPTH];
  logic        wr_req, rd_req, commit, latch_word, wr_ok, drive;

  function automatic logic in_range(input logic [19:0] a);
    return (a >> DEPTH_LOG2) == 20'd0;
  endfunction

  assign wr_req = !CE && !WE;
  assign rd_req = !CE && !OE && WE;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    raddr_nxt  = raddr;
    commit     = 1'b0;
    latch_word = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          commit    = 1'b1;
          state_nxt = WRITE_HOLD;
        end else if (rd_req) begin
          raddr_nxt = ADDR;
          cnt_nxt   = 4'(READ_LATENCY - 1);
          state_nxt = READ_WAIT;
        end
      end
      WRITE_HOLD: begin
        if (CE || WE) state_nxt = IDLE;
      end
      READ_WAIT, READ_DRIVE: begin
        // Abort outranks an address change; a changed address restarts full latency.
        if (!rd_req) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (ADDR != raddr) begin
          raddr_nxt = ADDR;
          cnt_nxt   = 4'(READ_LATENCY - 1);
          state_nxt = READ_WAIT;
        end else if (state == READ_WAIT) begin
          if (cnt == 4'd0) begin
            latch_word = 1'b1;
            state_nxt  = READ_DRIVE;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      raddr <= 20'd0;
      rdata <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      raddr <= raddr_nxt;
      if (latch_word)
        rdata <= in_range(raddr) ? mem[raddr[DEPTH_LOG2-1:0]] : 16'h0000;
    end
  end

  // Array contents survive reset; a write coinciding with reset is dropped.
  assign wr_ok = !Reset && commit && in_range(ADDR);

  always_ff @(posedge Clk) begin
    if (wr_ok) begin
      if (!UB) mem[ADDR[DEPTH_LOG2-1:0]][15:8] <= Data[15:8];
      if (!LB) mem[ADDR[DEPTH_LOG2-1:0]][7:0]  <= Data[7:0];
    end
  end

  assign drive      = (state == READ_DRIVE);
  assign Ready      = drive;
  assign Data[15:8] = (drive && !UB) ? rdata[15:8] : 8'hzz;
  assign Data[7:0]  = (drive && !LB) ? rdata[7:0]  : 8'hzz;

`ifdef SRAM_RESPONDER_STATS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_count  <= 16'd0;
      write_count <= 16'd0;
    end else begin
      if (latch_word && read_count != 16'hFFFF) read_count <= read_count + 16'd1;
      if (wr_ok && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboarded bench for sram_responder: reads push expected words, a negedge monitor checks them.
module tb_sram_responder;

  logic        Clk = 1'b0;
  logic        Reset, CE, OE, WE, UB, LB;
  logic [19:0] ADDR;
  wire  [15:0] Data;
  logic        Ready;
  logic [15:0] drv;
  logic        drv_en;
`ifdef SRAM_RESPONDER_STATS_EN
  logic [15:0] read_count, write_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model[int];
  logic        prev_ready = 1'b0;

  always #5 Clk = ~Clk;

  // Undriven lanes float high so released bytes read as 8'hFF.
  assign Data = drv_en ? drv : 16'hzzzz;
  for (genvar gi = 0; gi < 16; gi++) begin : g_pu
    pullup (Data[gi]);
  end

  sram_responder dut (
    .Clk(Clk), .Reset(Reset), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
    .ADDR(ADDR), .Data(Data),
`ifdef SRAM_RESPONDER_STATS_EN
    .read_count(read_count), .write_count(write_count),
`endif
    .Ready(Ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per rising Ready.
  always @(negedge Clk) begin
    if (Ready && !prev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got Data %h with empty scoreboard", Data);
      end else begin
        chk("read_data", 32'(Data), 32'(exp_q.pop_front()));
      end
    end
    prev_ready = Ready;
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] mread(input logic [19:0] a);
    if ((a >> 10) != 0) return 16'h0000;
    return model.exists(int'(a)) ? model[int'(a)] : 16'h0000;
  endfunction

  function automatic void mwrite(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    logic [15:0] w;
    if ((a >> 10) != 0) return;
    w = model.exists(int'(a)) ? model[int'(a)] : 16'h0000;
    if (!ub) w[15:8] = d[15:8];
    if (!lb) w[7:0] = d[7:0];
    model[int'(a)] = w;
  endfunction

  function automatic logic [15:0] lanes(input logic [15:0] w, input logic ub, input logic lb);
    logic [15:0] r;
    r = w;
    if (ub) r[15:8] = 8'hFF;
    if (lb) r[7:0] = 8'hFF;
    return r;
  endfunction

  task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    ADDR = a; drv = d; drv_en = 1'b1; UB = ub; LB = lb;
    CE = 1'b0; WE = 1'b0; OE = 1'b1;
    cyc();
    CE = 1'b1; WE = 1'b1; drv_en = 1'b0;
    cyc();
    mwrite(a, d, ub, lb);
  endtask

  task automatic rd(input logic [19:0] a, input logic ub, input logic lb);
    exp_q.push_back(lanes(mread(a), ub, lb));
    ADDR = a; UB = ub; LB = lb;
    CE = 1'b0; OE = 1'b0; WE = 1'b1;
    cyc();
    chk("rd_ready_k", 32'(Ready), 32'd0);
    cyc();
    chk("rd_ready_k1", 32'(Ready), 32'd0);
    cyc();
    chk("rd_ready_k2", 32'(Ready), 32'd1);
    CE = 1'b1; OE = 1'b1;
    cyc();
    chk("rd_release_ready", 32'(Ready), 32'd0);
    chk("rd_release_data", 32'(Data), 32'hFFFF);
    UB = 1'b0; LB = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b0; LB = 1'b0;
    ADDR = 20'd0; drv = 16'd0; drv_en = 1'b0;
    cyc(); cyc();
    Reset = 1'b0;
    chk("reset_ready", 32'(Ready), 32'd0);
    chk("reset_data_z", 32'(Data), 32'hFFFF);

    wr(20'd3, 16'hBEEF, 1'b0, 1'b0);
    rd(20'd3, 1'b0, 1'b0);

    // Byte-lane merge and lane-gated drive
    wr(20'd5, 16'h1234, 1'b0, 1'b0);
    wr(20'd5, 16'hAB00, 1'b0, 1'b1);
    rd(20'd5, 1'b0, 1'b0);
    rd(20'd5, 1'b1, 1'b0);
    rd(20'd5, 1'b0, 1'b1);

    // One commit per WE-low interval
    ADDR = 20'd7; UB = 1'b0; LB = 1'b0; OE = 1'b1; CE = 1'b0; WE = 1'b0; drv_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drv = 16'(i);
      cyc();
    end
    CE = 1'b1; WE = 1'b1; drv_en = 1'b0;
    cyc();
    mwrite(20'd7, 16'h0001, 1'b0, 1'b0);
    rd(20'd7, 1'b0, 1'b0);

    // Address change mid-wait restarts latency on the new word
    exp_q.push_back(mread(20'd5));
    ADDR = 20'd3; CE = 1'b0; OE = 1'b0; WE = 1'b1;
    cyc();
    chk("chg_ready_k", 32'(Ready), 32'd0);
    ADDR = 20'd5;
    cyc();
    chk("chg_ready_c0", 32'(Ready), 32'd0);
    cyc();
    chk("chg_ready_c1", 32'(Ready), 32'd0);
    cyc();
    chk("chg_ready_c2", 32'(Ready), 32'd1);
    CE = 1'b1; OE = 1'b1;
    cyc();

    // Out of range: read zero, writes ignored and do not alias
    rd(20'h00400, 1'b0, 1'b0);
    wr(20'h00403, 16'h5555, 1'b0, 1'b0);
    wr(20'd3, 16'h0000, 1'b1, 1'b1);
    rd(20'd3, 1'b0, 1'b0);

    // Aborted read never raises Ready
    ADDR = 20'd5; CE = 1'b0; OE = 1'b0; WE = 1'b1;
    cyc();
    OE = 1'b1;
    cyc();
    chk("abort_ready0", 32'(Ready), 32'd0);
    cyc();
    chk("abort_ready1", 32'(Ready), 32'd0);
    CE = 1'b1;
    cyc();

    // Reset during READ_DRIVE
    exp_q.push_back(mread(20'd3));
    ADDR = 20'd3; CE = 1'b0; OE = 1'b0; WE = 1'b1;
    cyc(); cyc(); cyc();
    chk("rstdrv_ready_pre", 32'(Ready), 32'd1);
    Reset = 1'b1;
    cyc();
    chk("rstdrv_ready", 32'(Ready), 32'd0);
    chk("rstdrv_data_z", 32'(Data), 32'hFFFF);
    CE = 1'b1; OE = 1'b1; Reset = 1'b0;
    cyc();

    // Write coinciding with reset does not commit
    Reset = 1'b1; ADDR = 20'd3; CE = 1'b0; WE = 1'b0; OE = 1'b1; drv = 16'h0F0F; drv_en = 1'b1;
    cyc();
    Reset = 1'b0; CE = 1'b1; WE = 1'b1; drv_en = 1'b0;
    cyc();
    rd(20'd3, 1'b0, 1'b0);

`ifdef SRAM_RESPONDER_STATS_EN
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    chk("stats_reset_w", 32'(write_count), 32'd0);
    chk("stats_reset_r", 32'(read_count), 32'd0);
    wr(20'd10, 16'h0A0A, 1'b0, 1'b0);
    wr(20'd11, 16'h0B0B, 1'b0, 1'b0);
    wr(20'd12, 16'h0C0C, 1'b0, 1'b0);
    rd(20'd10, 1'b0, 1'b0);
    rd(20'd12, 1'b0, 1'b0);
    ADDR = 20'd11; CE = 1'b0; OE = 1'b0; WE = 1'b1;
    cyc();
    CE = 1'b1; OE = 1'b1;
    cyc();
    chk("stats_write_count", 32'(write_count), 32'd3);
    chk("stats_read_count", 32'(read_count), 32'd2);
`endif

    cyc(); cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning internal word array depth is 2^DEPTH_LOG2 16-bit words.
REQ-002 SHALL have parameter READ_LATENCY, default 2, meaning cycles from read-request sample to Data valid; legal range 1..15.
REQ-003 SHALL have port Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port CE  input  1  chip enable, active-low.
REQ-006 SHALL have port OE  input  1  output enable, active-low.
REQ-007 SHALL have port WE  input  1  write enable, active-low.
REQ-008 SHALL have port UB  input  1  upper byte lane (Data[15:8]) select, active-low.
REQ-009 SHALL have port LB  input  1  lower byte lane (Data[7:0]) select, active-low.
REQ-010 SHALL have port ADDR  input  20  word address from the processor memory bus.
REQ-011 SHALL have port Data  inout  16  bidirectional data bus; driven only per REQ-019.
REQ-012 SHALL have port Ready  output  1  high while Data carries valid read data.

Function
REQ-013 SHALL implement states IDLE, READ_WAIT, READ_DRIVE, WRITE_HOLD.
REQ-014 Access decode at each edge: write = CE=0 & WE=0; read = CE=0 & OE=0 & WE=1; write has priority when OE=0 and WE=0 together.
REQ-015 IDLE + write: SHALL commit selected lanes of Data to word ADDR at that edge, go to WRITE_HOLD.
REQ-016 WRITE_HOLD: no further commits; SHALL return to IDLE at the first edge with CE=1 or WE=1 (one write per WE-low interval).
REQ-017 IDLE + read: SHALL latch ADDR, load wait counter with READ_LATENCY-1, go to READ_WAIT (READ_LATENCY=1 goes straight to READ_DRIVE after the latency edge).
REQ-018 READ_WAIT: counter decrements each edge; at zero SHALL latch array word and enter READ_DRIVE, so Data is valid after edge k+READ_LATENCY for request sampled at edge k.
REQ-019 READ_DRIVE: Data[15:8] driven iff UB=0, Data[7:0] driven iff LB=0, else high-impedance per lane; Ready=1; otherwise Data fully high-impedance and Ready=0.
REQ-020 Read abort: in READ_WAIT or READ_DRIVE, CE=1 or OE=1 or WE=0 at an edge SHALL release Data and go to IDLE (write then evaluated from IDLE next edge).
REQ-021 Address change: in READ_WAIT or READ_DRIVE, ADDR differing from latched address SHALL relatch and restart READ_WAIT with full latency; Ready=0 meanwhile.
REQ-022 Out of range: ADDR[19:DEPTH_LOG2] nonzero SHALL read 16'h0000 and SHALL ignore writes.
REQ-023 Write with UB=1 and LB=1 SHALL change no memory but still enter WRITE_HOLD.

Reset
REQ-024 Reset at an edge SHALL force IDLE, Ready=0, Data high-impedance, wait counter 0, regardless of current state.
REQ-025 Reset SHALL NOT clear array contents; a write sampled at the same edge as Reset SHALL NOT commit.

Configuration
REQ-026 Macro SRAM_RESPONDER_STATS_EN defined: adds outputs read_count[15:0] and write_count[15:0], incrementing on each REQ-018 completion and each REQ-015 commit, saturating at 16'hFFFF, zeroed by Reset.
REQ-027 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-028 Reset, write 16'hBEEF to ADDR 3 (UB=LB=0), then read ADDR 3 with defaults -> Data=16'hBEEF, Ready=1 exactly 2 edges after read sample.
REQ-029 Write 16'h1234 to ADDR 5, then write 16'hAB00 with LB=1 -> read ADDR 5 returns 16'hAB34; read with UB=1 -> Data[15:8]=Z, Data[7:0]=8'h34.
REQ-030 Hold WE=0 for 5 cycles while Data changes 16'h0001..16'h0005 -> word holds 16'h0001 only.
REQ-031 During READ_WAIT change ADDR 3->5 -> Ready stays 0, Data valid with word 5 two edges after change; ADDR=20'h00400 read -> 16'h0000.
REQ-032 Assert Reset during READ_DRIVE -> next edge Data=Z, Ready=0; subsequent read of ADDR 3 still returns 16'hBEEF.
REQ-033 With SRAM_RESPONDER_STATS_EN, 3 writes + 2 completed reads + 1 aborted read -> write_count=3, read_count=2.
